// File: rtl/word_tx_scheduler_pkg.sv
// Shared types and widths for the word-to-byte transmit scheduler.
package word_tx_scheduler_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Byte index within a word; BYTES is limited to 1..4.
  typedef logic [1:0] idx_t;

endpackage

// File: rtl/word_tx_scheduler_byte_mux.sv
// Combinational byte select: picks byte 'index' of a word in transmit order.
module word_byte_mux
  import word_tx_scheduler_pkg::*;
#(
  parameter int BYTES     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [WORD_W-1:0] word,
  input  idx_t              index,
  output logic [BYTE_W-1:0] byte_sel
);

  localparam idx_t LAST = idx_t'(BYTES - 1);

  idx_t sel;

  always_comb begin
    sel      = MSB_FIRST ? idx_t'(LAST - index) : index;
    byte_sel = word[{sel, 3'b000} +: BYTE_W];
  end

endmodule

// File: rtl/word_tx_scheduler.sv
// Round-robin arbiter between two word requesters feeding one byte-wide
// valid/ready sink; the granted word is captured and streamed BYTES bytes long.
module word_tx_scheduler
  import word_tx_scheduler_pkg::*;
#(
  parameter int BYTES     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [WORD_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              busy,
  output logic              grant_id
);

  // Handshake rule for every port here: a transfer happens on a rising clk
  // edge where valid && ready; the sender holds data stable until then.

  localparam idx_t LAST = idx_t'(BYTES - 1);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] word_q;
  idx_t              index_q;
  logic              last_grant_q;
  logic              grant_id_q;
  logic              pick1;
  logic              accept;
  logic              byte_fire;
  logic              last_byte;
  logic [BYTE_W-1:0] mux_byte;

  word_byte_mux #(
    .BYTES     (BYTES),
    .MSB_FIRST (MSB_FIRST)
  ) u_mux (
    .word     (word_q),
    .index    (index_q),
    .byte_sel (mux_byte)
  );

  always_comb begin
    // req1 wins when alone, or when both ask and req0 had the last grant.
    pick1      = req1_valid && (!req0_valid || !last_grant_q);
    req0_ready = (state_q == ST_IDLE) && req0_valid && !pick1;
    req1_ready = (state_q == ST_IDLE) && pick1;
    accept     = req0_ready || req1_ready;
    byte_valid = (state_q == ST_SEND);
    busy       = (state_q == ST_SEND);
    byte_out   = byte_valid ? mux_byte : '0;
    grant_id   = grant_id_q;
    byte_fire  = byte_valid && byte_ready;
    last_byte  = (index_q == LAST);

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_SEND;
      ST_SEND: if (byte_fire && last_byte) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      word_q       <= '0;
      index_q      <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_q       <= pick1 ? req1_data : req0_data;
        grant_id_q   <= pick1;
        last_grant_q <= pick1;
        index_q      <= '0;
      end else if (byte_fire && !last_byte) begin
        index_q <= index_q + idx_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_word_tx_scheduler.sv
// Bench for word_tx_scheduler: default instance plus a BYTES=2, MSB_FIRST=1 instance.
module tb_word_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          busy_cnt = 0;
  logic [7:0]  exp_q[$];

  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic [7:0]  byte_out;
  logic        byte_valid, byte_ready, busy, grant_id;

  logic        b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
  logic [31:0] b_req0_data, b_req1_data;
  logic [7:0]  b_byte_out;
  logic        b_byte_valid, b_byte_ready, b_busy, b_grant_id;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  word_tx_scheduler dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .grant_id(grant_id)
  );

  word_tx_scheduler #(.BYTES(2), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
    .byte_out(b_byte_out), .byte_valid(b_byte_valid), .byte_ready(b_byte_ready),
    .busy(b_busy), .grant_id(b_grant_id)
  );

  // Scoreboard: every byte handshake pops the next expected byte.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_cnt++;
      if (byte_valid && byte_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL byte_unexpected got %h with empty expected queue", byte_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (byte_out !== e) begin
            errors++;
            $display("FAIL byte_order got %h exp %h", byte_out, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [31:0] d);
    for (int k = 0; k < 4; k++) exp_q.push_back(d[8*k +: 8]);
  endtask

  task automatic wait_any_ready(output int got);
    got = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) begin got = 2; break; end
      if (req0_ready) begin got = 0; break; end
      if (req1_ready) begin got = 1; break; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0; byte_ready = 0;
    b_req0_valid = 0; b_req1_valid = 0; b_req0_data = '0; b_req1_data = '0; b_byte_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({byte_valid, byte_out, busy, grant_id, req0_ready, req1_ready} !== 13'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b out=%h busy=%b gid=%b r0=%b r1=%b exp all 0",
               byte_valid, byte_out, busy, grant_id, req0_ready, req1_ready);
    end
    checks++;
    if ({b_byte_valid, b_byte_out, b_busy, b_grant_id} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs_b got v=%b out=%h busy=%b exp 0", b_byte_valid, b_byte_out, b_busy);
    end
  endtask

  task automatic test_single();
    int got;
    bit ok;
    byte_ready = 1;
    @(posedge clk); #1;
    req0_valid = 1; req0_data = 32'hAABBCCDD;
    push_word(32'hAABBCCDD);
    wait_any_ready(got);
    checks++;
    if (got !== 0) begin errors++; $display("FAIL single_grant got %0d exp 0", got); end
    @(posedge clk); #1;
    req0_valid = 0; busy_cnt = 0;
    @(negedge clk);
    checks++;
    if (!(busy && grant_id === 1'b0)) begin
      errors++; $display("FAIL single_grant_id got busy=%b gid=%b exp 1 0", busy, grant_id);
    end
    wait_idle(ok);
    checks++;
    if (!ok || busy_cnt !== 4) begin
      errors++; $display("FAIL single_busy_cycles got %0d exp 4 (idle=%b)", busy_cnt, ok);
    end
    checks++;
    if (exp_q.size() !== 0 || grant_id !== 1'b0) begin
      errors++; $display("FAIL single_drain got left=%0d gid=%b exp 0 0", exp_q.size(), grant_id);
    end
  endtask

  task automatic test_backpressure();
    int got;
    bit ok;
    byte_ready = 1;
    @(posedge clk); #1;
    req0_valid = 1; req0_data = 32'h11223344;
    push_word(32'h11223344);
    wait_any_ready(got);
    checks++;
    if (got !== 0) begin errors++; $display("FAIL bp_grant got %0d exp 0", got); end
    @(posedge clk); #1;
    req0_valid = 0; busy_cnt = 0;
    @(posedge clk); #1;
    byte_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (!(byte_valid === 1'b1 && byte_out === 8'h33)) begin
        errors++; $display("FAIL bp_hold got v=%b out=%h exp 1 33", byte_valid, byte_out);
      end
    end
    @(posedge clk); #1;
    byte_ready = 1;
    wait_idle(ok);
    checks++;
    if (!ok || busy_cnt !== 7) begin
      errors++; $display("FAIL bp_send_cycles got %0d exp 7", busy_cnt);
    end
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_drain got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_drop();
    int got;
    bit ok;
    byte_ready = 1;
    @(posedge clk); #1;
    req0_valid = 1; req0_data = 32'h55667788;
    push_word(32'h55667788);
    wait_any_ready(got);
    checks++;
    if (got !== 0) begin errors++; $display("FAIL drop_grant got %0d exp 0", got); end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 1; req1_data = 32'h99999999;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (req1_ready !== 1'b0) begin errors++; $display("FAIL drop_ready_in_send got %b exp 0", req1_ready); end
      @(posedge clk);
    end
    #1 req1_valid = 0;
    wait_idle(ok);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || byte_valid !== 1'b0) begin
        errors++; $display("FAIL drop_no_capture got busy=%b v=%b exp 0 0", busy, byte_valid);
      end
    end
    checks++;
    if (!ok || exp_q.size() !== 0) begin errors++; $display("FAIL drop_drain got %0d left exp 0", exp_q.size()); end
  endtask

  task automatic test_idle_noise();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      byte_ready = 1'($urandom_range(0, 1));
      b_byte_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if ({byte_valid, busy, req0_ready, req1_ready, b_byte_valid, b_busy} !== 6'b0) begin
        errors++;
        $display("FAIL idle_noise got v=%b busy=%b r0=%b r1=%b bv=%b bbusy=%b exp all 0",
                 byte_valid, busy, req0_ready, req1_ready, b_byte_valid, b_busy);
      end
    end
  endtask

  task automatic test_msb();
    bit found;
    logic [7:0] exp_b[2];
    exp_b[0] = 8'h56; exp_b[1] = 8'h78;
    b_byte_ready = 1;
    @(posedge clk); #1;
    b_req0_valid = 1; b_req0_data = 32'h12345678;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_req0_ready) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL msb_grant got no ready exp ready"); end
    @(posedge clk); #1;
    b_req0_valid = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (!(b_byte_valid === 1'b1 && b_byte_out === exp_b[k])) begin
        errors++; $display("FAIL msb_byte%0d got v=%b out=%h exp 1 %h", k, b_byte_valid, b_byte_out, exp_b[k]);
      end
    end
    @(negedge clk);
    checks++;
    if ({b_byte_valid, b_busy, b_byte_out} !== 10'b0) begin
      errors++; $display("FAIL msb_idle got v=%b busy=%b out=%h exp 0 0 00", b_byte_valid, b_busy, b_byte_out);
    end
  endtask

  task automatic test_contention();
    int got;
    int prev;
    bit ok;
    do_reset();
    byte_ready = 1;
    @(posedge clk); #1;
    req0_valid = 1; req0_data = 32'h0A0B0C0D;
    req1_valid = 1; req1_data = 32'h01020304;
    for (int g = 0; g < 4; g++) push_word((g % 2 == 0) ? 32'h0A0B0C0D : 32'h01020304);
    prev = 0;
    for (int g = 0; g < 4; g++) begin
      wait_any_ready(got);
      checks++;
      if (got !== (g % 2)) begin errors++; $display("FAIL contention_order%0d got %0d exp %0d", g, got, g % 2); end
      if (g > 0) begin
        checks++;
        if (cyc - prev !== 5) begin errors++; $display("FAIL contention_gap got %0d exp 5", cyc - prev); end
      end
      prev = cyc;
      @(posedge clk);
    end
    #1 req0_valid = 0; req1_valid = 0;
    wait_idle(ok);
    checks++;
    if (!ok || exp_q.size() !== 0 || grant_id !== 1'b1) begin
      errors++; $display("FAIL contention_end got left=%0d gid=%b exp 0 1", exp_q.size(), grant_id);
    end
  endtask

  task automatic test_reset_mid();
    int got;
    int acc;
    bit ok;
    byte_ready = 1;
    @(posedge clk); #1;
    req0_valid = 1; req0_data = 32'hDEADBEEF;
    push_word(32'hDEADBEEF);
    wait_any_ready(got);
    checks++;
    if (got !== 0) begin errors++; $display("FAIL rstmid_grant got %0d exp 0", got); end
    @(posedge clk); #1;
    req0_valid = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    #1;
    checks++;
    if ({byte_valid, byte_out, busy} !== 10'b0 || exp_q.size() !== 2) begin
      errors++; $display("FAIL rstmid_async got v=%b out=%h busy=%b left=%0d exp 0 00 0 2",
                         byte_valid, byte_out, busy, exp_q.size());
    end
    exp_q.delete();
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    req1_valid = 1; req1_data = 32'hCAFEF00D;
    push_word(32'hCAFEF00D);
    wait_any_ready(got);
    acc = cyc;
    checks++;
    if (got !== 1) begin errors++; $display("FAIL rstmid_req1_grant got %0d exp 1", got); end
    @(posedge clk); #1;
    req1_valid = 0;
    @(negedge clk);
    checks++;
    if (!(byte_valid === 1'b1 && byte_out === 8'h0D && grant_id === 1'b1 && cyc == acc + 1)) begin
      errors++; $display("FAIL rstmid_first_byte got v=%b out=%h gid=%b dt=%0d exp 1 0d 1 1",
                         byte_valid, byte_out, grant_id, cyc - acc);
    end
    wait_idle(ok);
    checks++;
    if (!ok || exp_q.size() !== 0) begin errors++; $display("FAIL rstmid_drain got %0d left exp 0", exp_q.size()); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_drop();
    test_idle_noise();
    test_msb();
    test_contention();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_tx_scheduler.md
Name: word_tx_scheduler

Overview:
- Shares one 32-to-8 byte serialization path between two 32-bit word requesters, e.g. processor output-port store (req0) and debug/monitor port (req1).
- Arbitrates round-robin, captures the granted word, and streams its bytes to a byte sink (UART TX / output port) with valid/ready flow control.
- Sits between the processor's I/O store path and the byte-wide peripheral.

Parameters:
- BYTES, 4, bytes sent per word (1..4); byte k = data[8k+7:8k].
- MSB_FIRST, 0, 0 = byte 0 first (little-endian order); 1 = byte BYTES-1 first.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  32  requester 0 word; held stable while req0_valid && !req0_ready.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  32  requester 1 word; same hold rule.
- req1_ready  output  1  requester 1 word accepted this cycle.
- byte_out  output  8  current byte to sink.
- byte_valid  output  1  byte_out is valid.
- byte_ready  input  1  sink accepts byte_out this cycle.
- busy  output  1  a word is being sent (state SEND).
- grant_id  output  1  source of the word being sent; holds its last value when idle.

Behaviour:
- Reset (asynchronous) values:
  - state=IDLE; byte_valid=0; byte_out=8'h00; busy=0; grant_id=0; req0_ready=req1_ready=0.
  - Byte index=0; shift register=0.
  - last_grant=1, so req0 wins the first contention.
- States: IDLE, SEND.
- IDLE:
  - reqN_ready is combinational: (state==IDLE) && reqN_valid && arbiter picks N. At most one ready is high.
  - Arbiter: only one valid -> grant it. Both valid -> grant !last_grant.
  - On accept (valid&&ready):
    - Register the word; grant_id<=N; last_grant<=N; index<=0.
    - state<=SEND.
  - No valid -> remain IDLE, all outputs idle.
- SEND:
  - byte_valid=1 and busy=1, both registered, asserted the cycle after accept.
  - byte_out = selected byte of the captured word at index (MSB_FIRST mapping applied). It is stable while byte_valid && !byte_ready.
  - On byte_valid && byte_ready:
    - Not last byte: index<=index+1.
    - Index == BYTES-1: state<=IDLE; byte_valid<=0; byte_out<=0.
  - No new word is accepted while in SEND; reqN_ready=0.
- Latency:
  - Accept cycle T -> first byte valid at T+1.
  - With byte_ready held high, bytes occupy T+1..T+BYTES.
  - IDLE at T+BYTES+1; the next word is accepted no earlier than T+BYTES+1 (one bubble cycle).
- Boundary conditions:
  - byte_ready high outside SEND is ignored.
  - Valid dropped by a requester before ready: no capture, no state change.
  - Index wrap: the index never exceeds BYTES-1; it returns to 0 on the next accept.
  - BYTES=1: a single-byte transfer, then IDLE.
  - Reset asserted mid-SEND: the transfer is aborted immediately and outputs go to reset values. The partially sent word is dropped, not resent.
  - Simultaneous valid rising on both requesters in the cycle after a grant to req0: req1 is granted next (fairness). No requester waits more than one word.

Decomposition:
- Shared package/include: state encodings (ST_IDLE=1'b0, ST_SEND=1'b1), BYTE_W=8, WORD_W=32.
- One natural sub-module: word_byte_mux, a combinational byte select (word, index, MSB_FIRST) -> byte. The FSM, arbiter and capture register stay in word_tx_scheduler.

Test Plan:
- Single word, default parameters: req0_valid with 32'hAABBCCDD, byte_ready=1 -> req0_ready high one cycle; byte_out DD,CC,BB,AA on the next 4 cycles; busy high for 4 cycles; grant_id=0.
- Backpressure: word 32'h11223344; byte_ready low for 3 cycles at byte index 1 -> byte_out holds 33 with byte_valid=1; then 22, 11 follow; total 7 SEND cycles.
- Contention: both valid continuously, req0=32'h0A0B0C0D, req1=32'h01020304 -> grant order req0, req1, req0, req1; req1 bytes are 04,03,02,01; exactly one bubble cycle between words.
- Reset mid-operation: assert reset after 2 bytes of 32'hDEADBEEF -> byte_valid=0, byte_out=00 and busy=0 asynchronously. After release with req1 valid only, req1 is granted and its first byte appears 1 cycle after accept.
- MSB_FIRST=1, BYTES=2: word 32'h12345678 -> bytes 56 then 78; back to IDLE after 2 accepted bytes.
- Idle noise: byte_ready toggling with no valid requests -> byte_valid stays 0, state stays IDLE, no ready pulses.
